// File: rtl/ga23_rom_arbiter.sv
// rtl/ga23_rom_arbiter.sv - four-port round-robin tile-ROM arbiter onto one 64-bit SDRAM channel
// Toggle-handshake responder with a per-port one-line hit buffer in front of the SDRAM path.
module ga23_rom_arbiter #(
    parameter logic [24:0] BASE_ADDR = 25'h0,
    parameter bit          CACHE_EN  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [21:0] i_addr_a,
    input  logic [21:0] i_addr_b,
    input  logic [21:0] i_addr_c,
    input  logic [21:0] i_addr_d,
    input  logic        i_req_a,
    input  logic        i_req_b,
    input  logic        i_req_c,
    input  logic        i_req_d,
    output logic [31:0] o_data_a,
    output logic [31:0] o_data_b,
    output logic [31:0] o_data_c,
    output logic [31:0] o_data_d,
    output logic        o_rdy_a,
    output logic        o_rdy_b,
    output logic        o_rdy_c,
    output logic        o_rdy_d,
    output logic [24:0] o_sdr_addr,
    input  logic [63:0] i_sdr_data,
    output logic        o_sdr_req,
    input  logic        i_sdr_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [21:0] w_addr [4];
    logic [3:0]  w_req;
    logic [3:0]  w_pending;
    logic [3:0]  w_hit;
    logic [3:0]  w_cand;
    logic [1:0]  w_grant;
    logic        w_grant_ok;
    logic        w_sdr_done;

    logic [3:0]  r_rdy;
    logic [31:0] r_data [4];
    logic [20:0] r_tag  [4];
    logic [63:0] r_line [4];
    logic [3:0]  r_valid;
    logic [1:0]  r_owner;
    logic [1:0]  r_ptr;
    logic [24:0] r_sdr_addr;
    logic        r_sdr_req;

    assign w_addr[0] = i_addr_a;
    assign w_addr[1] = i_addr_b;
    assign w_addr[2] = i_addr_c;
    assign w_addr[3] = i_addr_d;
    assign w_req     = {i_req_d, i_req_c, i_req_b, i_req_a};

    assign o_data_a   = r_data[0];
    assign o_data_b   = r_data[1];
    assign o_data_c   = r_data[2];
    assign o_data_d   = r_data[3];
    assign o_rdy_a    = r_rdy[0];
    assign o_rdy_b    = r_rdy[1];
    assign o_rdy_c    = r_rdy[2];
    assign o_rdy_d    = r_rdy[3];
    assign o_sdr_addr = r_sdr_addr;
    assign o_sdr_req  = r_sdr_req;

    assign w_sdr_done = (i_sdr_rdy == r_sdr_req);

    // The SDRAM owner is excluded from the hit path so it can never be served twice.
    always_comb begin
        w_pending = w_req ^ r_rdy;
        w_hit     = 4'b0;
        for (int i = 0; i < 4; i++) begin
            w_hit[i] = CACHE_EN && w_pending[i] && r_valid[i]
                       && (r_tag[i] == w_addr[i][21:1])
                       && !((r_state != S_IDLE) && (r_owner == 2'(i)));
        end
        w_cand = w_pending & ~w_hit;
    end

    // Search starts just after the last owner; k == 4 wraps back onto the pointer itself.
    always_comb begin
        logic [1:0] w_idx;
        w_grant    = r_ptr;
        w_grant_ok = 1'b0;
        w_idx      = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_grant_ok && w_cand[w_idx]) begin
                w_grant    = w_idx;
                w_grant_ok = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_ok) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (w_sdr_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rdy      <= 4'b0;
            r_valid    <= 4'b0;
            r_owner    <= 2'd0;
            r_ptr      <= 2'd0;
            r_sdr_addr <= 25'h0;
            r_sdr_req  <= i_sdr_rdy;
            for (int i = 0; i < 4; i++) begin
                r_data[i] <= 32'h0;
                r_tag[i]  <= 21'h0;
                r_line[i] <= 64'h0;
            end
        end else begin
            r_state <= w_state_next;
            for (int i = 0; i < 4; i++) begin
                if (w_hit[i]) begin
                    r_data[i] <= w_addr[i][0] ? r_line[i][63:32] : r_line[i][31:0];
                    r_rdy[i]  <= w_req[i];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ok) begin
                        r_owner    <= w_grant;
                        r_sdr_addr <= BASE_ADDR + {w_addr[w_grant][21:1], 3'b000};
                    end
                end
                S_ISSUE: r_sdr_req <= ~r_sdr_req;
                S_WAIT: begin
                    if (w_sdr_done) begin
                        r_tag[r_owner]   <= w_addr[r_owner][21:1];
                        r_line[r_owner]  <= i_sdr_data;
                        r_valid[r_owner] <= CACHE_EN;
                        r_data[r_owner]  <= w_addr[r_owner][0] ? i_sdr_data[63:32]
                                                               : i_sdr_data[31:0];
                        r_rdy[r_owner]   <= w_req[r_owner];
                        r_ptr            <= r_owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ga23_rom_arbiter.sv
// tb/tb_ga23_rom_arbiter.sv - randomized self-checking bench for ga23_rom_arbiter
// Instance 0 has the hit buffer enabled, instance 1 has it disabled.
module tb_ga23_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [21:0] addr [2][4];
    logic        req  [2][4];
    logic [31:0] data [2][4];
    logic        rdy  [2][4];
    logic [24:0] sdr_addr [2];
    logic [63:0] sdr_data [2];
    logic        sdr_req  [2];
    logic        sdr_rdy  [2] = '{1'b0, 1'b0};

    int          lat [2] = '{0, 0};
    int          toggles [2] = '{0, 0};
    int          r_cnt [2];
    bit          r_busy [2];
    logic [24:0] gq [$];
    bit          mv [2][4];
    logic [20:0] mtag [2][4];
    int          n_tests = 0;
    int          n_fail  = 0;

    ga23_rom_arbiter #(.BASE_ADDR(25'h0), .CACHE_EN(1'b1)) u_dut_c (
        .i_clk(clk), .i_reset(reset),
        .i_addr_a(addr[0][0]), .i_addr_b(addr[0][1]), .i_addr_c(addr[0][2]), .i_addr_d(addr[0][3]),
        .i_req_a(req[0][0]), .i_req_b(req[0][1]), .i_req_c(req[0][2]), .i_req_d(req[0][3]),
        .o_data_a(data[0][0]), .o_data_b(data[0][1]), .o_data_c(data[0][2]), .o_data_d(data[0][3]),
        .o_rdy_a(rdy[0][0]), .o_rdy_b(rdy[0][1]), .o_rdy_c(rdy[0][2]), .o_rdy_d(rdy[0][3]),
        .o_sdr_addr(sdr_addr[0]), .i_sdr_data(sdr_data[0]),
        .o_sdr_req(sdr_req[0]), .i_sdr_rdy(sdr_rdy[0])
    );

    ga23_rom_arbiter #(.BASE_ADDR(25'h0), .CACHE_EN(1'b0)) u_dut_nc (
        .i_clk(clk), .i_reset(reset),
        .i_addr_a(addr[1][0]), .i_addr_b(addr[1][1]), .i_addr_c(addr[1][2]), .i_addr_d(addr[1][3]),
        .i_req_a(req[1][0]), .i_req_b(req[1][1]), .i_req_c(req[1][2]), .i_req_d(req[1][3]),
        .o_data_a(data[1][0]), .o_data_b(data[1][1]), .o_data_c(data[1][2]), .o_data_d(data[1][3]),
        .o_rdy_a(rdy[1][0]), .o_rdy_b(rdy[1][1]), .o_rdy_c(rdy[1][2]), .o_rdy_d(rdy[1][3]),
        .o_sdr_addr(sdr_addr[1]), .i_sdr_data(sdr_data[1]),
        .o_sdr_req(sdr_req[1]), .i_sdr_rdy(sdr_rdy[1])
    );

    function automatic logic [63:0] fdata(input logic [24:0] a);
        if (a == 25'h40) return 64'h11112222_33334444;
        return {7'h0, a, 32'hC0DE0000 ^ {7'h0, a}};
    endfunction

    function automatic logic [31:0] exp_word(input logic [21:0] a);
        logic [63:0] l;
        l = fdata(25'((a >> 1) * 8));
        return (a % 2 == 1) ? l[63:32] : l[31:0];
    endfunction

    // SDRAM responder: answers each request toggle after lat[k] further clocks.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                r_busy[k] = 1'b0;
            end else if (sdr_req[k] !== sdr_rdy[k]) begin
                if (!r_busy[k]) begin
                    r_busy[k] = 1'b1;
                    r_cnt[k]  = lat[k];
                    toggles[k]++;
                    if (k == 0) gq.push_back(sdr_addr[k]);
                end
                if (r_cnt[k] == 0) begin
                    sdr_data[k] = fdata(sdr_addr[k]);
                    sdr_rdy[k]  = sdr_req[k];
                    r_busy[k]   = 1'b0;
                end else begin
                    r_cnt[k]--;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) begin
                req[k][p]  = 1'b0;
                addr[k][p] = 22'h0;
                mv[k][p]   = 1'b0;
            end
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // One request on port p of instance k; checks completion and data, updates the line model.
    task automatic access(input int k, input int p, input logic [21:0] a,
                          output int cyc, output bit hit);
        hit = (k == 0) && mv[k][p] && (mtag[k][p] == a[21:1]);
        addr[k][p] = a;
        req[k][p]  = ~req[k][p];
        cyc = 0;
        while (rdy[k][p] !== req[k][p] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("done k%0d p%0d", k, p), rdy[k][p], req[k][p]);
        check($sformatf("data k%0d p%0d a%0h", k, p, a), data[k][p], exp_word(a));
        if (!hit && k == 0) begin
            mv[k][p]   = 1'b1;
            mtag[k][p] = a[21:1];
        end
    endtask

    task automatic seq_pair(input int k);
        int c; bit h; int t0;
        lat[k] = 5;
        t0 = toggles[k];
        access(k, 0, 22'h000010, c, h);
        check("t1 sdr_addr", sdr_addr[k], 25'h000040);
        check("t1 sdr toggles", toggles[k] - t0, 1);
        check("t1 latency", c, 8);
        t0 = toggles[k];
        access(k, 0, 22'h000011, c, h);
        check("t2 data", data[k][0], 32'h11112222);
        check("t2 sdr toggles", toggles[k] - t0, (k == 0) ? 0 : 1);
        check("t2 latency", c, (k == 0) ? 1 : 8);
    endtask

    task automatic round(input int k);
        int cyc [4]; bit hp [4]; bit use_p [4]; logic [21:0] a [4];
        int t0; int nmiss;
        lat[k] = $urandom_range(0, 4);
        t0 = toggles[k];
        nmiss = 0;
        for (int p = 0; p < 4; p++) begin
            use_p[p] = ($urandom_range(0, 2) != 0);
            hp[p] = 1'b0;
            cyc[p] = 0;
            if (mv[k][p] && $urandom_range(0, 1) == 1)
                a[p] = {mtag[k][p], 1'($urandom_range(0, 1))};
            else
                a[p] = 22'($urandom_range(0, 31));
        end
        fork
            if (use_p[0]) access(k, 0, a[0], cyc[0], hp[0]);
            if (use_p[1]) access(k, 1, a[1], cyc[1], hp[1]);
            if (use_p[2]) access(k, 2, a[2], cyc[2], hp[2]);
            if (use_p[3]) access(k, 3, a[3], cyc[3], hp[3]);
        join
        for (int p = 0; p < 4; p++) begin
            if (use_p[p] && hp[p]) check($sformatf("hit latency p%0d", p), cyc[p], 1);
            if (use_p[p] && !hp[p]) nmiss++;
        end
        check($sformatf("round sdr toggles k%0d", k), toggles[k] - t0, nmiss);
    endtask

    initial begin
        int c; int ca; int cb; bit h; bit ha; bit hb; int t0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) begin
                check("reset rdy", rdy[k][p], 1'b0);
                check("reset data", data[k][p], 32'h0);
            end
            check("reset sdr_addr", sdr_addr[k], 25'h0);
            check("reset sdr_req", sdr_req[k], sdr_rdy[k]);
        end

        seq_pair(0);
        seq_pair(1);

        // Hit on b while a owns the SDRAM channel
        lat[0] = 10;
        access(0, 1, 22'h000020, c, h);
        fork
            access(0, 0, 22'h000030, ca, ha);
            begin
                repeat (4) @(negedge clk);
                access(0, 1, 22'h000021, cb, hb);
            end
        join
        check("t4 b latency", cb, 1);
        check("t4 a latency", ca, 13);

        // Round-robin order after d was the last owner, then wrap from d to a
        lat[0] = 1;
        access(0, 3, 22'h000100, c, h);
        gq.delete();
        fork
            access(0, 0, 22'h000200, c, h);
            access(0, 1, 22'h000210, ca, ha);
            access(0, 2, 22'h000220, cb, hb);
            access(0, 3, 22'h000230, t0, h);
        join
        check("t3 grants", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++)
            check($sformatf("t3 grant %0d", i), gq[i], 25'h800 + 25'(i * 'h40));
        gq.delete();
        fork
            access(0, 0, 22'h000300, c, h);
            access(0, 2, 22'h000320, ca, ha);
        join
        check("t3b grants", gq.size(), 2);
        if (gq.size() == 2) begin
            check("t3b first", gq[0], 25'hC00);
            check("t3b second", gq[1], 25'hC80);
        end

        // Reset while waiting on SDRAM with sdr_rdy high
        do_reset();
        lat[0] = 2;
        for (int i = 0; i < 3 && sdr_rdy[0] !== 1'b1; i++)
            access(0, 0, 22'(22'h400 + i * 2), c, h);
        lat[0] = 50;
        addr[0][0] = 22'h000050;
        req[0][0]  = ~req[0][0];
        repeat (6) @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < 4; p++) req[0][p] = 1'b0;
        repeat (2) @(negedge clk);
        check("t5 sdr_req", sdr_req[0], 1'b1);
        for (int p = 0; p < 4; p++) check("t5 rdy", rdy[0][p], 1'b0);
        check("t5 data", data[0][0], 32'h0);
        do_reset();
        t0 = toggles[0];
        repeat (70) @(negedge clk);
        check("t5 no sdr", toggles[0] - t0, 0);
        check("t5 no rdy", rdy[0][0], 1'b0);

        do_reset();
        for (int r = 0; r < 40; r++) begin
            round(0);
            round(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
